// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encoding shared with the ALU, sequencer state enum and operand-decode helper
package cpu_pkg;
  localparam logic [3:0] OP_HLT = 4'h0, OP_SKZ = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4, OP_OR = 4'h5, OP_AND = 4'h6, OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8, OP_STO = 4'h9, OP_LDA = 4'hA, OP_RL = 4'hB;
  localparam logic [3:0] OP_RR = 4'hC, OP_JMP = 4'hD, OP_POP = 4'hE, OP_PUSH = 4'hF;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_WB, S_STORE, S_HALT
  } state_t;
  function automatic logic needs_operand(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_NOT) || (op >= OP_LDA && op <= OP_RR);
  endfunction
endpackage

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction sequencer; mem_* = registered memory port, alu_* = ALU operands/result, halted/pc_out = status
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              ctrl_clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        alu_opcode,
  output logic [15:0]       alu_data,
  output logic [15:0]       alu_accum,
  input  logic [15:0]       alu_out,
  input  logic              alu_zero,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);
  state_t state, nxt;
  logic [15:0] acc, ir, opnd;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [3:0] op;
  logic rd_done, wr_done;
  assign op = ir[15:12];
  assign rd_done = mem_rd & mem_ready;
  assign wr_done = mem_wr & mem_ready;
  assign mem_wdata = acc;
  assign alu_accum = acc;
  assign alu_data = opnd;
  assign alu_opcode = state == S_EXEC ? op : OP_HLT;
  assign halted = state == S_HALT;
  assign pc_out = pc;
  always_comb begin
    nxt = state;
    pc_nxt = pc;
    case (state)
      S_FETCH: nxt = rd_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        pc_nxt = op == OP_JMP ? ir[ADDR_W-1:0] :
                 op == OP_HLT ? pc :
                 (op == OP_SKZ && alu_zero) ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
        nxt = op == OP_HLT ? S_HALT :
              (op == OP_SKZ || op == OP_JMP) ? S_FETCH :
              needs_operand(op) ? S_OPERAND :
              op == OP_STO ? S_STORE : S_EXEC;
      end
      S_OPERAND: nxt = rd_done ? S_EXEC : S_OPERAND;
      S_EXEC: nxt = S_WB;
      S_WB: nxt = S_FETCH;
      S_STORE: nxt = wr_done ? S_FETCH : S_STORE;
      default: nxt = S_HALT;
    endcase
  end
  // requests are registered from the next state so they rise on state entry and drop on completion
  always_ff @(posedge ctrl_clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      acc <= '0;
      ir <= '0;
      opnd <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= nxt;
      pc <= pc_nxt;
      if (state == S_FETCH && rd_done) ir <= mem_rdata;
      if (state == S_OPERAND && rd_done) opnd <= mem_rdata;
      if (state == S_WB && op != OP_PUSH) acc <= alu_out;
      mem_rd <= nxt == S_FETCH || nxt == S_OPERAND;
      mem_wr <= nxt == S_STORE;
      mem_addr <= nxt == S_FETCH ? pc_nxt :
                  (nxt == S_OPERAND || nxt == S_STORE) ? ir[ADDR_W-1:0] : mem_addr;
    end
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: self-checking bench with memory/ALU environment and an instruction-level reference model
module tb_cpu_ctrl;
  import cpu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [11:0] mem_addr, pc_out;
  logic mem_rd, mem_wr, mem_ready, halted, alu_zero;
  logic [15:0] mem_wdata, mem_rdata, alu_data, alu_accum, alu_out;
  logic [3:0] alu_opcode;
  logic [11:0] w_addr, w_pc;
  logic w_rd, w_wr, w_halted;
  logic [15:0] w_wdata, w_data, w_accum, wrap_ins = 16'h0;
  logic [3:0] w_opcode;
  int checks = 0, errors = 0;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] stk [$];
  int req_idx = 0, cnt = 0, tgt_rand = 0, stall_idx = -1, stall_len = 0, rand_max = 0;
  bit force_ready = 1'b0;

  cpu_ctrl u_dut (
    .ctrl_clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_accum(alu_accum),
    .alu_out(alu_out), .alu_zero(alu_zero), .halted(halted), .pc_out(pc_out)
  );
  cpu_ctrl #(.RESET_PC(12'hFFF)) u_wrap (
    .ctrl_clk(clk), .rst(rst), .mem_addr(w_addr), .mem_rd(w_rd), .mem_wr(w_wr),
    .mem_wdata(w_wdata), .mem_rdata(w_addr == 12'hFFF ? wrap_ins : 16'h0000), .mem_ready(1'b1),
    .alu_opcode(w_opcode), .alu_data(w_data), .alu_accum(w_accum),
    .alu_out(16'h0000), .alu_zero(1'b1), .halted(w_halted), .pc_out(w_pc)
  );

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d);
    case (op)
      OP_ADD: return a + d;
      OP_SUB: return a - d;
      OP_MUL: return a * d;
      OP_OR:  return a | d;
      OP_AND: return a & d;
      OP_XOR: return a ^ d;
      OP_NOT: return ~d;
      OP_LDA: return d;
      OP_RL:  return {a[14:0], a[15]};
      OP_RR:  return {a[0], a[15:1]};
      default: return a;
    endcase
  endfunction

  assign alu_zero = alu_accum == 16'h0;
  always @(posedge clk) begin
    if (rst) stk.delete();
    if (alu_opcode == OP_PUSH) begin
      stk.push_back(alu_accum);
      alu_out <= alu_accum;
    end else if (alu_opcode == OP_POP) begin
      if (stk.size() > 0) alu_out <= stk.pop_back();
      else alu_out <= 16'h0;
    end else alu_out <= alu_f(alu_opcode, alu_accum, alu_data);
  end

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = force_ready | ((mem_rd | mem_wr) && cnt >= (req_idx == stall_idx ? stall_len : tgt_rand));
  always @(posedge clk) begin
    if (rst) begin
      req_idx <= 0;
      cnt <= 0;
    end else if ((mem_rd | mem_wr) && mem_ready) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      req_idx <= req_idx + 1;
      cnt <= 0;
      tgt_rand <= int'($urandom_range(0, rand_max));
    end else if (mem_rd | mem_wr) cnt <= cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst && (mem_rd || mem_wr)) begin
      checks++;
      if (mem_rd && mem_wr) begin errors++; $display("FAIL rd_wr_exclusive rd=%b wr=%b expected not both", mem_rd, mem_wr); end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
  endtask

  task automatic put(input int a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      ok = halted;
    end
  endtask

  task automatic iss(output logic [15:0] acc, output logic [11:0] pc, output int cyc);
    logic [15:0] s [$];
    logic [15:0] ins;
    acc = 16'h0;
    pc = 12'h0;
    cyc = 1;
    for (int n = 0; n < 500 && ref_mem[pc][15:12] != OP_HLT; n++) begin
      ins = ref_mem[pc];
      case (ins[15:12])
        OP_SKZ: begin pc += (acc == 16'h0) ? 12'd2 : 12'd1; cyc += 2; end
        OP_JMP: begin pc = ins[11:0]; cyc += 2; end
        OP_STO: begin ref_mem[ins[11:0]] = acc; pc += 12'd1; cyc += 3; end
        OP_PUSH: begin s.push_back(acc); pc += 12'd1; cyc += 4; end
        OP_POP: begin acc = s.size() > 0 ? s.pop_back() : 16'h0; pc += 12'd1; cyc += 4; end
        default: begin acc = alu_f(ins[15:12], acc, ref_mem[ins[11:0]]); pc += 12'd1; cyc += 5; end
      endcase
    end
    cyc += 2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_rd, mem_wr, halted} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {mem_rd, mem_wr, halted}); end
    checks++; if (mem_addr !== 12'h0 || pc_out !== 12'h0) begin errors++; $display("FAIL reset_addr_pc got %h/%h exp 000/000", mem_addr, pc_out); end
    checks++; if ({mem_wdata, alu_data, alu_accum} !== 48'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_wdata, alu_data, alu_accum); end
    checks++; if (alu_opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got %h exp 0", alu_opcode); end
  endtask

  task automatic test_program();
    int cyc;
    bit ok;
    clear_mem();
    put(0, 16'hA010); put(1, 16'h2011); put(2, 16'h9012); put(3, 16'h0000);
    put(16'h010, 16'h0005); put(16'h011, 16'h0003);
    do_reset();
    wait_halt(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL program_timeout halted=%b exp 1", halted); end
    checks++; if (mem[12'h012] !== 16'h0008) begin errors++; $display("FAIL program_store got %h exp 0008", mem[12'h012]); end
    checks++; if (pc_out !== 12'h003) begin errors++; $display("FAIL program_pc got %h exp 003", pc_out); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL program_cycles got %0d exp 16", cyc); end
    force_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (!halted || mem_rd || pc_out !== 12'h003) begin errors++; $display("FAIL halt_hold halted=%b rd=%b pc=%h exp 1/0/003", halted, mem_rd, pc_out); end
    force_ready = 1'b0;
  endtask

  task automatic test_skz();
    int cyc;
    bit ok;
    for (int v = 0; v < 2; v++) begin
      clear_mem();
      put(0, 16'hA010); put(1, 16'hD004); put(4, 16'h1000); put(16'h010, 16'(v));
      do_reset();
      wait_halt(cyc, ok);
      checks++; if (!ok || pc_out !== (v == 0 ? 12'h006 : 12'h005)) begin errors++; $display("FAIL skz_acc%0d pc=%h halted=%b exp %h", v, pc_out, halted, v == 0 ? 12'h006 : 12'h005); end
    end
  endtask

  task automatic test_jmp();
    clear_mem();
    put(0, 16'hD0FF);
    do_reset();
    @(posedge clk); @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin errors++; $display("FAIL first_fetch rd=%b addr=%h exp 1/000", mem_rd, mem_addr); end
    @(posedge clk); @(negedge clk);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL jmp_decode rd=%b exp 0", mem_rd); end
    @(posedge clk); @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h0FF) begin errors++; $display("FAIL jmp_target rd=%b addr=%h exp 1/0FF", mem_rd, mem_addr); end
  endtask

  task automatic test_wait();
    int cyc = 0, held = 0;
    clear_mem();
    put(0, 16'hA010); put(16'h010, 16'h1357);
    stall_idx = 1;
    stall_len = 3;
    do_reset();
    for (int i = 0; i < 100 && !halted; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mem_rd && req_idx == 1) begin
        held++;
        checks++; if (mem_addr !== 12'h010) begin errors++; $display("FAIL wait_addr got %h exp 010", mem_addr); end
      end
    end
    stall_idx = -1;
    checks++; if (held != 4) begin errors++; $display("FAIL wait_rd_cycles got %0d exp 4", held); end
    checks++; if (cyc != 11 || alu_accum !== 16'h1357) begin errors++; $display("FAIL wait_result cyc=%0d acc=%h exp 11/1357", cyc, alu_accum); end
  endtask

  task automatic test_push_pop();
    int cyc;
    bit ok;
    clear_mem();
    put(0, 16'hA010); put(1, 16'hF000); put(2, 16'hA011); put(3, 16'hE000); put(4, 16'h9012);
    put(16'h010, 16'hABCD); put(16'h011, 16'h1234);
    do_reset();
    wait_halt(cyc, ok);
    checks++; if (!ok || alu_accum !== 16'hABCD) begin errors++; $display("FAIL push_pop acc=%h halted=%b exp ABCD", alu_accum, halted); end
    checks++; if (mem[12'h012] !== 16'hABCD || cyc != 1 + 5 + 4 + 5 + 4 + 3 + 2) begin errors++; $display("FAIL push_pop_store mem=%h cyc=%0d exp ABCD/24", mem[12'h012], cyc); end
  endtask

  task automatic test_rst_store();
    bit seen = 1'b0;
    clear_mem();
    put(0, 16'hA010); put(1, 16'h9012); put(16'h010, 16'h0042); put(16'h012, 16'hDEAD);
    stall_idx = 3;
    stall_len = 1000;
    do_reset();
    for (int i = 0; i < 50 && !seen; i++) begin @(posedge clk); @(negedge clk); seen = mem_wr; end
    checks++; if (!seen || mem_addr !== 12'h012 || mem_wdata !== 16'h0042) begin errors++; $display("FAIL store_req wr=%b addr=%h data=%h exp 1/012/0042", mem_wr, mem_addr, mem_wdata); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_drop_wr got %b exp 0", mem_wr); end
    stall_idx = -1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h000 || mem[12'h012] !== 16'hDEAD) begin errors++; $display("FAIL rst_refetch rd=%b addr=%h mem=%h exp 1/000/DEAD", mem_rd, mem_addr, mem[12'h012]); end
  endtask

  task automatic test_wrap();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      wrap_ins = k == 0 ? 16'h8FFF : 16'h1000;
      do_reset();
      cyc = 0;
      for (int i = 0; i < 50 && !w_halted; i++) begin @(posedge clk); cyc++; @(negedge clk); end
      checks++; if (!w_halted || w_pc !== 12'(k) || w_addr !== 12'(k)) begin errors++; $display("FAIL pc_wrap%0d pc=%h addr=%h halted=%b exp %h", k, w_pc, w_addr, w_halted, 12'(k)); end
      checks++; if (cyc != (k == 0 ? 8 : 5)) begin errors++; $display("FAIL wrap_cycles%0d got %0d exp %0d", k, cyc, k == 0 ? 8 : 5); end
    end
  endtask

  task automatic test_random();
    int cyc, ecyc, n;
    bit ok;
    logic [15:0] eacc;
    logic [11:0] epc, a;
    logic [3:0] op;
    for (int k = 0; k < 10; k++) begin
      clear_mem();
      rand_max = k < 5 ? 0 : 2;
      n = int'($urandom_range(6, 14));
      for (int i = 0; i < 8; i++) put(2048 + i, 16'($urandom));
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom_range(1, 15));
        a = op == OP_JMP ? 12'($urandom_range(i + 1, n)) : 12'(2048 + $urandom_range(0, 7));
        put(i, {op, a});
      end
      do_reset();
      wait_halt(cyc, ok);
      iss(eacc, epc, ecyc);
      checks++; if (!ok || alu_accum !== eacc || pc_out !== epc) begin errors++; $display("FAIL random%0d acc=%h pc=%h halted=%b exp %h/%h", k, alu_accum, pc_out, halted, eacc, epc); end
      if (rand_max == 0) begin
        checks++; if (cyc != ecyc) begin errors++; $display("FAIL random%0d_cycles got %0d exp %0d", k, cyc, ecyc); end
      end
      for (int i = 0; i < 8; i++) begin
        checks++; if (mem[2048 + i] !== ref_mem[2048 + i]) begin errors++; $display("FAIL random%0d_mem%0d got %h exp %h", k, i, mem[2048 + i], ref_mem[2048 + i]); end
      end
    end
    rand_max = 0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_skz();
    test_jmp();
    test_wait();
    test_push_pop();
    test_rst_store();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
